// File: rtl/qmem_arbiter.sv
// rtl/qmem_arbiter.sv - MN-to-1 QMEM master arbiter with transfer lock and read-data return routing
// Build option QMEM_ARBITER_RR_EN: round-robin when defined, fixed lowest-index priority otherwise.
module qmem_arbiter #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW/8,
  parameter int MN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MN-1:0]    qm_cs,
  input  logic [MN-1:0]    qm_we,
  input  logic [MN*QSW-1:0] qm_sel,
  input  logic [MN*QAW-1:0] qm_adr,
  input  logic [MN*QDW-1:0] qm_dat_w,
  output logic [MN*QDW-1:0] qm_dat_r,
  output logic [MN-1:0]    qm_ack,
  output logic [MN-1:0]    qm_err,
  output logic             qs_cs,
  output logic             qs_we,
  output logic [QSW-1:0]   qs_sel,
  output logic [QAW-1:0]   qs_adr,
  output logic [QDW-1:0]   qs_dat_w,
  input  logic [QDW-1:0]   qs_dat_r,
  input  logic             qs_ack,
  input  logic             qs_err
);

  localparam int IW = 3;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] gnt, gnt_nxt;
  logic [IW-1:0] rd_own, rd_own_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] g;
  logic [7:0]    cs_ext;
  logic          found;
  logic          req;
  logic          xfer_end;

  always_comb begin
    cs_ext = '0;
    cs_ext[MN-1:0] = qm_cs;
  end

  // Two passes: indices at/after ptr first, then wrap around to the lower ones.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MN; i++) begin
      if (!found && qm_cs[i] && (IW'(i) >= ptr)) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < MN; i++) begin
      if (!found && qm_cs[i]) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign g        = (state == ST_LOCK) ? gnt : win;
  assign req      = (state == ST_LOCK) ? cs_ext[gnt] : found;
  assign qs_cs    = rst & req;
  assign xfer_end = qs_cs & (qs_ack | qs_err);

  always_comb begin
    qs_we    = 1'b0;
    qs_sel   = '0;
    qs_adr   = '0;
    qs_dat_w = '0;
    qm_ack   = '0;
    qm_err   = '0;
    qm_dat_r = '0;
    for (int i = 0; i < MN; i++) begin
      if (IW'(i) == g) begin
        qs_we    = qm_we[i];
        qs_sel   = qm_sel[i*QSW +: QSW];
        qs_adr   = qm_adr[i*QAW +: QAW];
        qs_dat_w = qm_dat_w[i*QDW +: QDW];
        qm_ack[i] = qs_cs & qs_ack;
        qm_err[i] = qs_cs & qs_err;
      end
      if (IW'(i) == rd_own) begin
        qm_dat_r[i*QDW +: QDW] = qs_dat_r;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rd_own_nxt = rd_own;
    if (xfer_end) begin
      state_nxt = ST_IDLE;
    end else if ((state == ST_IDLE) && qs_cs) begin
      state_nxt = ST_LOCK;
      gnt_nxt   = g;
    end else if ((state == ST_LOCK) && !qs_cs) begin
      // Granted master withdrew its request: abort without moving the RR base.
      state_nxt = ST_IDLE;
    end
    if (qs_cs && qs_ack && !qs_we) begin
      rd_own_nxt = g;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      rd_own <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rd_own <= rd_own_nxt;
    end
  end

`ifdef QMEM_ARBITER_RR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (xfer_end) begin
      ptr <= (g == IW'(MN-1)) ? '0 : g + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_qmem_arbiter.sv
// tb/tb_qmem_arbiter.sv - directed self-checking bench for qmem_arbiter with two masters
module tb_qmem_arbiter;

  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;
  localparam int MN  = 2;
`ifdef QMEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] ADR0 = 32'h0000_A000;
  localparam logic [31:0] ADR1 = 32'h0000_0100;
  localparam logic [31:0] DAT0 = 32'h1111_0000;
  localparam logic [31:0] DAT1 = 32'hDEAD_BEEF;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [MN-1:0]         qm_cs;
  logic [MN-1:0]         qm_we;
  logic [MN*QSW-1:0]     qm_sel;
  logic [MN*QAW-1:0]     qm_adr;
  logic [MN*QDW-1:0]     qm_dat_w;
  logic [MN*QDW-1:0]     qm_dat_r;
  logic [MN-1:0]         qm_ack;
  logic [MN-1:0]         qm_err;
  logic                  qs_cs;
  logic                  qs_we;
  logic [QSW-1:0]        qs_sel;
  logic [QAW-1:0]        qs_adr;
  logic [QDW-1:0]        qs_dat_w;
  logic [QDW-1:0]        qs_dat_r;
  logic                  qs_ack;
  logic                  qs_err;

  int n_checks = 0;
  int n_errors = 0;

  qmem_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN)) dut (
    .clk      (clk),
    .rst      (rst),
    .qm_cs    (qm_cs),
    .qm_we    (qm_we),
    .qm_sel   (qm_sel),
    .qm_adr   (qm_adr),
    .qm_dat_w (qm_dat_w),
    .qm_dat_r (qm_dat_r),
    .qm_ack   (qm_ack),
    .qm_err   (qm_err),
    .qs_cs    (qs_cs),
    .qs_we    (qs_we),
    .qs_sel   (qs_sel),
    .qs_adr   (qs_adr),
    .qs_dat_w (qs_dat_w),
    .qs_dat_r (qs_dat_r),
    .qs_ack   (qs_ack),
    .qs_err   (qs_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, leave time to settle before checks.
  task automatic cyc(input logic r, input logic [1:0] cs, input logic we,
                     input logic ack, input logic err, input logic [31:0] dr);
    @(posedge clk);
    #1;
    rst      = r;
    qm_cs    = cs;
    qm_we    = {we, we};
    qs_ack   = ack;
    qs_err   = err;
    qs_dat_r = dr;
    #4;
  endtask

  initial begin
    rst      = 1'b0;
    qm_cs    = '0;
    qm_we    = '0;
    qm_sel   = {4'hF, 4'h3};
    qm_adr   = {ADR1, ADR0};
    qm_dat_w = {DAT1, DAT0};
    qs_dat_r = '0;
    qs_ack   = 1'b0;
    qs_err   = 1'b0;

    // reset forces outputs low even with requests and responses present
    cyc(1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 32'h0);
    check("rst_qs_cs", 64'(qs_cs), 64'd0);
    check("rst_ack", 64'(qm_ack), 64'd0);
    check("rst_err", 64'(qm_err), 64'd0);

    // single master 1 write, ack on the fourth cycle
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t1_cs", 64'(qs_cs), 64'd1);
    check("t1_adr0", 64'(qs_adr), 64'(ADR1));
    check("t1_we", 64'(qs_we), 64'd1);
    check("t1_dat_w", 64'(qs_dat_w), 64'(DAT1));
    check("t1_sel", 64'(qs_sel), 64'hF);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
      check("t1_adr_hold", 64'(qs_adr), 64'(ADR1));
      check("t1_ack_wait", 64'(qm_ack), 64'd0);
    end
    cyc(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_ack", 64'(qm_ack), 64'b10);
    cyc(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_ptr0_adr", 64'(qs_adr), 64'(ADR0));
    check("t1_ptr0_ack", 64'(qm_ack), 64'b01);

    // contention with single-cycle acks from a fresh reset
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
      check("cont_adr", 64'(qs_adr), 64'((RR && k[0]) ? ADR1 : ADR0));
      check("cont_ack", 64'(qm_ack), 64'((RR && k[0]) ? 2'b10 : 2'b01));
    end

    // lock: master 0 held for four cycles, master 1 follows and then holds off master 0
    cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    check("lock_c0_adr", 64'(qs_adr), 64'(ADR0));
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
      check("lock_hold_adr", 64'(qs_adr), 64'(ADR0));
      check("lock_hold_ack", 64'(qm_ack), 64'd0);
    end
    cyc(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
    check("lock_end_adr", 64'(qs_adr), 64'(ADR0));
    check("lock_end_ack", 64'(qm_ack), 64'b01);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
    check("lock_next_cs", 64'(qs_cs), 64'd1);
    check("lock_next_adr", 64'(qs_adr), 64'(ADR1));
    cyc(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
    check("lock_m1_hold", 64'(qs_adr), 64'(ADR1));
    cyc(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
    check("lock_m1_ack", 64'(qm_ack), 64'b10);

    // read return to master 1
    cyc(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0);
    check("rd_we", 64'(qs_we), 64'd0);
    check("rd_ack", 64'(qm_ack), 64'b10);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    check("rd_slice1", 64'(qm_dat_r[63:32]), 64'h1234_5678);
    check("rd_slice0", 64'(qm_dat_r[31:0]), 64'd0);

    // abort while locked
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
    check("ab_c0_cs", 64'(qs_cs), 64'd1);
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
    check("ab_cs_low", 64'(qs_cs), 64'd0);
    check("ab_ack_low", 64'(qm_ack), 64'd0);
    cyc(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
    check("ab_ptr_adr", 64'(qs_adr), 64'(ADR0));
    check("ab_ptr_ack", 64'(qm_ack), 64'b01);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
    check("ab2_lock_adr", 64'(qs_adr), 64'(ADR1));
    cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    check("ab2_cs_low", 64'(qs_cs), 64'd0);
    cyc(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0);
    check("ab2_clear_cs", 64'(qs_cs), 64'd1);
    check("ab2_clear_adr", 64'(qs_adr), 64'(ADR0));
    check("ab2_clear_ack", 64'(qm_ack), 64'b01);

    // err on a read keeps the previous read owner
    cyc(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0);
    check("err_rd0_ack", 64'(qm_ack), 64'b01);
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h55AA_55AA);
    check("err_m1", 64'(qm_err), 64'b10);
    check("err_no_ack", 64'(qm_ack), 64'd0);
    check("err_rd0_data", 64'(qm_dat_r[31:0]), 64'h55AA_55AA);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D);
    check("err_own_s0", 64'(qm_dat_r[31:0]), 64'h0BAD_F00D);
    check("err_own_s1", 64'(qm_dat_r[63:32]), 64'd0);

    // reset while locked on master 1
    cyc(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rm_pre_ack", 64'(qm_ack), 64'b01);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rm_lock_adr", 64'(qs_adr), 64'(ADR1));
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 32'h0);
      check("rm_cs", 64'(qs_cs), 64'd0);
      check("rm_ack", 64'(qm_ack), 64'd0);
      check("rm_err", 64'(qm_err), 64'd0);
    end
    cyc(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rm_tie_adr", 64'(qs_adr), 64'(ADR0));
    check("rm_tie_ack", 64'(qm_ack), 64'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qmem_arbiter.md
# qmem_arbiter

Multi-master QMEM arbiter: merges MN QMEM master ports onto one QMEM master port that feeds the QMEM address decoder, or a single slave. A grant is locked for the whole transfer, from chip-select to ack/err. Read data returns one cycle after ack, to the master whose read was acknowledged. Fairness is round-robin, or fixed priority by build option.

## Interface
Parameters:
- QAW, 32, address width
- QDW, 32, data width
- QSW, QDW/8, byte-select width
- MN, 2, number of masters (1..8)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- qm_cs  in  MN  per-master chip-select
- qm_we  in  MN  per-master write enable
- qm_sel  in  MN*QSW  per-master byte select, master i at [QSW*(i+1)-1:QSW*i]
- qm_adr  in  MN*QAW  per-master address, same packing
- qm_dat_w  in  MN*QDW  per-master write data, same packing
- qm_dat_r  out  MN*QDW  per-master read data
- qm_ack  out  MN  per-master acknowledge
- qm_err  out  MN  per-master error
- qs_cs, qs_we  out  1  downstream chip-select and write enable
- qs_sel  out  QSW  downstream byte select
- qs_adr  out  QAW  downstream address
- qs_dat_w  out  QDW  downstream write data
- qs_dat_r  in  QDW  downstream read data, valid the cycle after ack
- qs_ack, qs_err  in  1  downstream acknowledge and error

## Operation
- State: `lock` (1b), `gnt` (3b, granted index), `ptr` (3b, round-robin base), `rd_own` (3b, owner of the next read-data beat).
- IDLE (`lock`=0):
  - Winner: the first asserted qm_cs scanning ptr, ptr+1, … mod MN.
  - The winner is granted combinationally in the same cycle.
  - No qm_cs asserted: qs_cs=0.
- Forwarding: qs_cs/we/sel/adr/dat_w = the granted master's fields.
- Response routing: qm_ack[g]=qs_ack and qm_err[g]=qs_err for the granted index g only; every other master's ack/err is 0.
- Transfer end, in either state: qs_cs & (qs_ack|qs_err) ends the transfer. The FSM goes to IDLE and `ptr`←(g+1) mod MN.
- Lock: in IDLE, a granted request that is not acked/errored in that cycle sets `lock`=1 and `gnt`=g. The grant then holds regardless of other requests.
- Abort: while `lock`=1, if qm_cs[gnt] deasserts without ack/err, then qs_cs=0 that cycle, `lock`←0, and `ptr` is unchanged.
- Read owner: on qs_cs & qs_ack & ~qs_we, `rd_own`←g.
- Read data: qm_dat_r[rd_own] = qs_dat_r; all other masters' slices are 0.
- Error handling: err on a read does not update `rd_own`.
- MN=1: arbitration degenerates to a pass-through; the `ptr` logic is constant 0.

## Timing
- Grant and forwarding: 0 cycles, combinational, for both a fresh request and a locked grant.
- ack/err path: combinational, qs_ack → qm_ack[g].
- Read data: reaches the owner 1 cycle after ack, matching downstream registered read data.
- Back-to-back: a new winner can be granted in the cycle after ack. A master that stays requesting after its ack waits behind other requesters (round-robin).
- Simultaneous events: ack in the same cycle as the first grant means no lock, ptr advances, and a single-cycle transfer.
- Reset, while rst=0:
  - State: `lock`←0, `ptr`←0, `gnt`←0, `rd_own`←0.
  - Outputs forced: qs_cs=0, qm_ack=0, qm_err=0.
  - Other qs_* outputs are don't-care.
- Reset mid-transfer: the transfer is dropped. The first cycle after reset arbitrates from ptr=0.

## Configuration
- QMEM_ARBITER_RR_EN defined: round-robin as above.
- QMEM_ARBITER_RR_EN undefined: fixed priority, lowest index wins. `ptr` is removed (constant 0). Locking, abort and read-owner behaviour are unchanged.

## Test plan
- Single master: MN=2, master 1 writes adr 0x100, dat 0xDEADBEEF, slave acks after 3 cycles. Required response:
  - qs_adr=0x100 from the first cycle.
  - qm_ack[1] pulses once.
  - qm_ack[0] stays 0.
  - ptr=0 afterwards.
- Contention, RR: masters 0 and 1 request continuously with single-cycle acks. Required response:
  - Grants alternate 0,1,0,1.
  - Undefined macro: master 0 always wins.
- Lock: master 0 is granted with a 4-cycle ack delay; master 1 raises cs in cycle 1. Required response:
  - qs_adr stays at master 0's address until ack.
  - Master 1 is granted the next cycle.
- Read return: master 1 reads, slave acks, next cycle qs_dat_r=0x12345678. Required response:
  - qm_dat_r slice 1 = 0x12345678.
  - Slice 0 = 0.
- Abort and err: master 0 drops cs while locked, then qs_cs=0 in that cycle, lock clears and ptr is unchanged. An err on master 1's read gives qm_err[1]=1 and leaves rd_own unchanged.
- Reset mid-transfer: rst low for 2 cycles while locked on master 1. Required response:
  - qs_cs=0 and all acks 0 during reset.
  - After reset, master 0 wins a tie.
